// File: rtl/idif_fft8_core.sv
// idif_fft8_core: 8-point inverse FFT, radix-2 decimation-in-frequency, fully parallel.
// Three registered butterfly stages; each stage halves, so the output is scaled by 1/8.
// Outputs are in natural order. The stage-3 bit-reverse is undone in wiring ahead of
// the last register.
// Build option: define IFFT_ROUND_EN for round-half-up on every shift. By default every
// shift truncates toward -inf.
module idif_fft8_core #(
  parameter int unsigned W       = 9,
  parameter int unsigned TW_FRAC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inr0,
  input  logic [W-1:0] inr1,
  input  logic [W-1:0] inr2,
  input  logic [W-1:0] inr3,
  input  logic [W-1:0] inr4,
  input  logic [W-1:0] inr5,
  input  logic [W-1:0] inr6,
  input  logic [W-1:0] inr7,
  input  logic [W-1:0] ini0,
  input  logic [W-1:0] ini1,
  input  logic [W-1:0] ini2,
  input  logic [W-1:0] ini3,
  input  logic [W-1:0] ini4,
  input  logic [W-1:0] ini5,
  input  logic [W-1:0] ini6,
  input  logic [W-1:0] ini7,
  output logic [W-1:0] outreal0,
  output logic [W-1:0] outreal1,
  output logic [W-1:0] outreal2,
  output logic [W-1:0] outreal3,
  output logic [W-1:0] outreal4,
  output logic [W-1:0] outreal5,
  output logic [W-1:0] outreal6,
  output logic [W-1:0] outreal7,
  output logic [W-1:0] outimag0,
  output logic [W-1:0] outimag1,
  output logic [W-1:0] outimag2,
  output logic [W-1:0] outimag3,
  output logic [W-1:0] outimag4,
  output logic [W-1:0] outimag5,
  output logic [W-1:0] outimag6,
  output logic [W-1:0] outimag7
);

  // Product width: the sample, the constant, and headroom for sum and negation.
  localparam int unsigned PW = W + TW_FRAC + 2;
  // cos(pi/4) in fixed point; 181 at TW_FRAC = 8.
  localparam int TwC = $rtoi(0.7071 * (2.0 ** TW_FRAC) + 0.5);
  localparam logic signed [PW-1:0] TwCS = PW'(TwC);

  // (a +/- b) >>> 1. A two-bit-wider intermediate leaves room for the rounding offset.
  function automatic logic signed [W-1:0] half_sum(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b,
                                                   input logic sub);
    logic signed [W+1:0] t;
    t = sub ? ((W+2)'(a) - (W+2)'(b)) : ((W+2)'(a) + (W+2)'(b));
`ifdef IFFT_ROUND_EN
    t = t + (W+2)'(1);
`endif
    return t[W:1];
  endfunction

  // (+/-C*a +/- C*b) >>> TW_FRAC; covers the real and imaginary halves of the odd twiddles.
  function automatic logic signed [W-1:0] tw_mac(input logic signed [W-1:0] a,
                                                 input logic neg_a,
                                                 input logic signed [W-1:0] b,
                                                 input logic neg_b);
    logic signed [PW-1:0] pa, pb, t;
    pa = PW'(a) * TwCS;
    pb = PW'(b) * TwCS;
    if (neg_a) pa = -pa;
    if (neg_b) pb = -pb;
    t = pa + pb;
`ifdef IFFT_ROUND_EN
    t = t + (PW'(1) << (TW_FRAC - 1));
`endif
    return t[TW_FRAC +: W];
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] p);
    return {p[0], p[1], p[2]};
  endfunction

  logic signed [W-1:0] x_re [8];
  logic signed [W-1:0] x_im [8];
  logic signed [W-1:0] d1_re [4];
  logic signed [W-1:0] d1_im [4];
  logic signed [W-1:0] s1_re_d [8];
  logic signed [W-1:0] s1_im_d [8];
  logic signed [W-1:0] s1_re_q [8];
  logic signed [W-1:0] s1_im_q [8];
  logic signed [W-1:0] s2_re_d [8];
  logic signed [W-1:0] s2_im_d [8];
  logic signed [W-1:0] s2_re_q [8];
  logic signed [W-1:0] s2_im_q [8];
  logic signed [W-1:0] s3_re_d [8];
  logic signed [W-1:0] s3_im_d [8];
  logic signed [W-1:0] s3_re_q [8];
  logic signed [W-1:0] s3_im_q [8];

  assign x_re = '{inr0, inr1, inr2, inr3, inr4, inr5, inr6, inr7};
  assign x_im = '{ini0, ini1, ini2, ini3, ini4, ini5, ini6, ini7};

  // Stage 1: span-4 butterflies. The differences are rotated by e^(+j*pi*n/4).
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      s1_re_d[n] = half_sum(x_re[n], x_re[n+4], 1'b0);
      s1_im_d[n] = half_sum(x_im[n], x_im[n+4], 1'b0);
      d1_re[n]   = half_sum(x_re[n], x_re[n+4], 1'b1);
      d1_im[n]   = half_sum(x_im[n], x_im[n+4], 1'b1);
    end
    s1_re_d[4] = d1_re[0];
    s1_im_d[4] = d1_im[0];
    // (1+j)/sqrt2: re = C(a-b), im = C(a+b)
    s1_re_d[5] = tw_mac(d1_re[1], 1'b0, d1_im[1], 1'b1);
    s1_im_d[5] = tw_mac(d1_re[1], 1'b0, d1_im[1], 1'b0);
    // +j: swap and negate. Negating the most negative value wraps; inputs never reach it.
    s1_re_d[6] = -d1_im[2];
    s1_im_d[6] = d1_re[2];
    // (-1+j)/sqrt2: re = -C(a+b), im = C(a-b)
    s1_re_d[7] = tw_mac(d1_re[3], 1'b1, d1_im[3], 1'b1);
    s1_im_d[7] = tw_mac(d1_re[3], 1'b0, d1_im[3], 1'b1);
  end

  // Stage 2: span-2 butterflies within each half. The second difference is rotated by +j.
  always_comb begin
    logic signed [W-1:0] dr, di;
    dr = '0;
    di = '0;
    for (int g = 0; g < 8; g += 4) begin
      for (int m = 0; m < 2; m++) begin
        s2_re_d[g+m] = half_sum(s1_re_q[g+m], s1_re_q[g+m+2], 1'b0);
        s2_im_d[g+m] = half_sum(s1_im_q[g+m], s1_im_q[g+m+2], 1'b0);
        dr = half_sum(s1_re_q[g+m], s1_re_q[g+m+2], 1'b1);
        di = half_sum(s1_im_q[g+m], s1_im_q[g+m+2], 1'b1);
        if (m == 0) begin
          s2_re_d[g+m+2] = dr;
          s2_im_d[g+m+2] = di;
        end else begin
          s2_re_d[g+m+2] = -di;
          s2_im_d[g+m+2] = dr;
        end
      end
    end
  end

  // Stage 3: span-1 butterflies. Results are stored bit-reverse-mapped into natural order.
  always_comb begin
    for (int p = 0; p < 8; p += 2) begin
      s3_re_d[bitrev3(3'(p))]     = half_sum(s2_re_q[p], s2_re_q[p+1], 1'b0);
      s3_im_d[bitrev3(3'(p))]     = half_sum(s2_im_q[p], s2_im_q[p+1], 1'b0);
      s3_re_d[bitrev3(3'(p + 1))] = half_sum(s2_re_q[p], s2_re_q[p+1], 1'b1);
      s3_im_d[bitrev3(3'(p + 1))] = half_sum(s2_im_q[p], s2_im_q[p+1], 1'b1);
    end
  end

  // Pipeline registers. Reset clears everything, so outputs read zero straight away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        s1_re_q[i] <= '0;
        s1_im_q[i] <= '0;
        s2_re_q[i] <= '0;
        s2_im_q[i] <= '0;
        s3_re_q[i] <= '0;
        s3_im_q[i] <= '0;
      end
    end else begin
      s1_re_q <= s1_re_d;
      s1_im_q <= s1_im_d;
      s2_re_q <= s2_re_d;
      s2_im_q <= s2_im_d;
      s3_re_q <= s3_re_d;
      s3_im_q <= s3_im_d;
    end
  end

  assign outreal0 = s3_re_q[0];
  assign outreal1 = s3_re_q[1];
  assign outreal2 = s3_re_q[2];
  assign outreal3 = s3_re_q[3];
  assign outreal4 = s3_re_q[4];
  assign outreal5 = s3_re_q[5];
  assign outreal6 = s3_re_q[6];
  assign outreal7 = s3_re_q[7];
  assign outimag0 = s3_im_q[0];
  assign outimag1 = s3_im_q[1];
  assign outimag2 = s3_im_q[2];
  assign outimag3 = s3_im_q[3];
  assign outimag4 = s3_im_q[4];
  assign outimag5 = s3_im_q[5];
  assign outimag6 = s3_im_q[6];
  assign outimag7 = s3_im_q[7];

endmodule

// File: tb/tb_idif_fft8_core.sv
// Scoreboard bench for idif_fft8_core: the driver queues hand-computed results, and the
// monitor pops and compares them three edges after the vector was sampled.
module tb_idif_fft8_core;

  typedef struct packed {
    logic [7:0][8:0] re;
    logic [7:0][8:0] im;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       drv_vld = 1'b0;
  logic [2:0] vp = '0;
  logic [8:0] inr [8];
  logic [8:0] ini [8];
  logic [8:0] outr [8];
  logic [8:0] outi [8];

  vec_t  exp_q [$];
  string tag_q [$];
  vec_t  zero_v = '0;
  int    n_pass = 0;
  int    n_tot = 0;

  always #5 clk = ~clk;

  idif_fft8_core dut (
    .clk(clk), .rst(rst),
    .inr0(inr[0]), .inr1(inr[1]), .inr2(inr[2]), .inr3(inr[3]),
    .inr4(inr[4]), .inr5(inr[5]), .inr6(inr[6]), .inr7(inr[7]),
    .ini0(ini[0]), .ini1(ini[1]), .ini2(ini[2]), .ini3(ini[3]),
    .ini4(ini[4]), .ini5(ini[5]), .ini6(ini[6]), .ini7(ini[7]),
    .outreal0(outr[0]), .outreal1(outr[1]), .outreal2(outr[2]), .outreal3(outr[3]),
    .outreal4(outr[4]), .outreal5(outr[5]), .outreal6(outr[6]), .outreal7(outr[7]),
    .outimag0(outi[0]), .outimag1(outi[1]), .outimag2(outi[2]), .outimag3(outi[3]),
    .outimag4(outi[4]), .outimag5(outi[5]), .outimag6(outi[6]), .outimag7(outi[7])
  );

  // Bench-side record of which sampled vectors were queued; three stages deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vp <= '0;
    else      vp <= {vp[1:0], drv_vld};
  end

  function automatic vec_t mkv(input int r [8], input int i [8]);
    vec_t v;
    for (int n = 0; n < 8; n++) begin
      v.re[n] = 9'(r[n]);
      v.im[n] = 9'(i[n]);
    end
    return v;
  endfunction

  task automatic check_vec(input vec_t e, input string tag);
    bit bad;
    bad = 1'b0;
    n_tot++;
    for (int n = 0; n < 8; n++) begin
      if (outr[n] !== e.re[n]) begin
        bad = 1'b1;
        $display("FAIL %s outreal%0d got %0d expected %0d", tag, n,
                 $signed(outr[n]), $signed(e.re[n]));
      end
      if (outi[n] !== e.im[n]) begin
        bad = 1'b1;
        $display("FAIL %s outimag%0d got %0d expected %0d", tag, n,
                 $signed(outi[n]), $signed(e.im[n]));
      end
    end
    if (!bad) n_pass++;
  endtask

  // Monitor: a queued result is due whenever the tracking pipe says so; otherwise zero.
  always @(negedge clk) begin
    if (vp[2]) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL scoreboard result due but queue empty");
      end else begin
        check_vec(exp_q.pop_front(), tag_q.pop_front());
      end
    end else begin
      check_vec(zero_v, "idle_zero");
    end
  end

  task automatic apply(input vec_t x, input vec_t e, input string tag);
    for (int n = 0; n < 8; n++) begin
      inr[n] = x.re[n];
      ini[n] = x.im[n];
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input vec_t x, input vec_t e, input string tag);
    @(posedge clk);
    #1;
    apply(x, e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t x_dc, e_dc, x_even, e_even, x_all, e_all, x_neg, e_neg, x_j2, e_j2;
    vec_t x_b1, e_b1, x_b3, e_b3;
    x_dc   = mkv('{8, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_dc   = mkv('{1, 1, 1, 1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});
    x_even = mkv('{2, 0, 2, 0, 2, 0, 2, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_even = mkv('{1, 0, 0, 0, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    x_all  = mkv('{2, 2, 2, 2, 2, 2, 2, 2}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_all  = mkv('{2, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    x_neg  = mkv('{-8, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_neg  = mkv('{-1, -1, -1, -1, -1, -1, -1, -1}, '{0, 0, 0, 0, 0, 0, 0, 0});
    // X[2] = 64j -> x[n] = 8j * j^n, exact in fixed point
    x_j2   = mkv('{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 64, 0, 0, 0, 0, 0});
    e_j2   = mkv('{0, -8, 0, 8, 0, -8, 0, 8}, '{8, 0, -8, 0, 8, 0, -8, 0});
    // X[1] = 64 -> 8*e^(j*pi*n/4); 0.7071 terms land on 5/-6 after truncation
    x_b1   = mkv('{0, 64, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_b1   = mkv('{8, 5, 0, -6, -8, -6, 0, 5}, '{0, 5, 8, 5, 0, -6, -8, -6});
    // X[3] = 64 -> 8*e^(j*3*pi*n/4)
    x_b3   = mkv('{0, 0, 0, 64, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    e_b3   = mkv('{8, -6, 0, 5, -8, 6, 0, -6}, '{0, 5, -8, 5, 0, -6, 8, -6});

    // Nonzero inputs under reset must not reach the outputs.
    for (int n = 0; n < 8; n++) begin
      inr[n] = 9'(100 + n);
      ini[n] = 9'(37 * n);
    end
    drv_vld = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(x_dc, e_dc, "dc_impulse");
    step(x_even, e_even, "even_bins");
    step(x_all, e_all, "all_equal");
    step(x_neg, e_neg, "neg_impulse");
    step(x_j2, e_j2, "imag_bin2");
`ifndef IFFT_ROUND_EN
    step(x_b1, e_b1, "bin1_twiddle");
    step(x_b3, e_b3, "bin3_twiddle");
`endif
    step(zero_v, zero_v, "zero");

    // Back-to-back stream, then reset while later vectors are still in flight.
    step(x_dc, e_dc, "b2b_dc");
    step(x_even, e_even, "b2b_even");
    step(x_all, e_all, "b2b_all");
    step(x_dc, e_dc, "flushed_a");
    step(x_even, e_even, "flushed_b");
    step(x_neg, e_neg, "flushed_c");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    #1;
    check_vec(zero_v, "rst_async_clear");
    repeat (2) @(posedge clk);

    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(x_neg, e_neg, "post_reset_neg");
    step(zero_v, zero_v, "zero_a");
    step(zero_v, zero_v, "zero_b");
    step(zero_v, zero_v, "zero_c");
    @(posedge clk);
    #1;
    drv_vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tot++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain queue left %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
